// File: rtl/sdram_dq_path_pkg.sv
// Shared SDRAM DQ datapath definitions: FSM state encoding and burst timing defaults
// common to this datapath and the command FSM.
package sdram_dq_path_pkg;

  localparam int DEF_BURST_LEN = 8;
  localparam int DEF_CAS_LAT   = 2;

  typedef enum logic [2:0] {
    DQ_IDLE,
    DQ_WRITE,
    DQ_W_TAIL,
    DQ_RD_WAIT,
    DQ_READ,
    DQ_TURN
  } dq_state_t;

endpackage

// File: rtl/sdram_rd_capture.sv
// Read capture: delays the nominal CAS data window by RD_DLY board-skew stages, samples DQ on the
// delayed strobe and pulses rd_vld the cycle after each sample; rd_dat holds between words.
module sdram_rd_capture #(
  parameter int DQ_W   = 16,
  parameter int RD_DLY = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cas_win,
  input  logic [DQ_W-1:0] dq,
  output logic [DQ_W-1:0] rd_dat,
  output logic            rd_vld
);

  logic smp_en;

  if (RD_DLY == 0) begin : g_no_dly
    assign smp_en = cas_win;
  end else begin : g_dly
    logic [RD_DLY-1:0] win_sr;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) win_sr <= '0;
      else        win_sr <= RD_DLY'({win_sr, cas_win});
    end

    assign smp_en = win_sr[RD_DLY-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_dat <= '0;
      rd_vld <= 1'b0;
    end else begin
      rd_vld <= smp_en;
      if (smp_en) rd_dat <= dq;
    end
  end

endmodule

// File: rtl/sdram_dq_path.sv
// SDRAM DQ datapath: write words drive DQ one cycle after the FIFO pop; read words are valid
// CAS_LAT+RD_DLY+1 cycles after rd_start's edge. SDRAM_DQM_EN adds wr_be and drives sdram_dqm.
module sdram_dq_path
  import sdram_dq_path_pkg::*;
#(
  parameter int DQ_W      = 16,
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int CAS_LAT   = DEF_CAS_LAT,
  parameter int RD_DLY    = 0,
  parameter int CNT_W     = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  inout  wire  [DQ_W-1:0]   sdram_data,
  output logic [DQ_W/8-1:0] sdram_dqm,
  input  logic              wr_start,
  input  logic [DQ_W-1:0]   wr_data_in,
`ifdef SDRAM_DQM_EN
  input  logic [DQ_W/8-1:0] wr_be,
`endif
  output logic              wr_data_req,
  input  logic              rd_start,
  output logic [DQ_W-1:0]   rd_data_out,
  output logic              rd_data_valid,
  output logic              busy,
  output logic              burst_done
);

  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(CAS_LAT + RD_DLY - 1);

  dq_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             oe;
  logic [DQ_W-1:0]  wr_dat;
  logic             cas_win;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DQ_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state || state == DQ_IDLE) cnt <= '0;
      else                                        cnt <= cnt + 1'b1;
    end
  end

  // cas_win marks cycles whose closing edge sees data at nominal CAS timing; the
  // capture block shifts it by RD_DLY so sampling lines up with the READ state.
  always_comb begin
    state_nxt   = state;
    wr_data_req = 1'b0;
    busy        = 1'b1;
    cas_win     = 1'b0;
    unique case (state)
      DQ_IDLE: begin
        busy = 1'b0;
        if (wr_start)      state_nxt = DQ_WRITE;
        else if (rd_start) state_nxt = DQ_RD_WAIT;
      end
      DQ_WRITE: begin
        wr_data_req = 1'b1;
        if (cnt == BURST_LAST) state_nxt = DQ_W_TAIL;
      end
      DQ_W_TAIL: state_nxt = DQ_TURN;
      DQ_RD_WAIT: begin
        cas_win = (int'(cnt) >= CAS_LAT) && (int'(cnt) < CAS_LAT + BURST_LEN);
        if (cnt == WAIT_LAST) state_nxt = DQ_READ;
      end
      DQ_READ: begin
        cas_win = int'(cnt) < BURST_LEN - RD_DLY;
        if (cnt == BURST_LAST) state_nxt = DQ_TURN;
      end
      DQ_TURN: state_nxt = DQ_IDLE;
      default: state_nxt = DQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oe         <= 1'b0;
      wr_dat     <= '0;
      burst_done <= 1'b0;
    end else begin
      oe         <= wr_data_req;
      burst_done <= (state == DQ_W_TAIL) || (state == DQ_READ && cnt == BURST_LAST);
      if (wr_data_req) wr_dat <= wr_data_in;
    end
  end

`ifdef SDRAM_DQM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           sdram_dqm <= '0;
    else if (wr_data_req) sdram_dqm <= ~wr_be;
    else                  sdram_dqm <= '0;
  end
`else
  assign sdram_dqm = '0;
`endif

  assign sdram_data = oe ? wr_dat : 'z;

  sdram_rd_capture #(
    .DQ_W   (DQ_W),
    .RD_DLY (RD_DLY)
  ) u_rd_capture (
    .clk     (clk),
    .rst_n   (rst_n),
    .cas_win (cas_win),
    .dq      (sdram_data),
    .rd_dat  (rd_data_out),
    .rd_vld  (rd_data_valid)
  );

endmodule

// File: tb/tb_sdram_dq_path.sv
// Bench for sdram_dq_path: two instances (CL2/RD_DLY0 and CL3/RD_DLY1) share stimulus and are
// checked per cycle against a burst-timing model that also plays the SDRAM on each DQ bus.
module tb_sdram_dq_path;

  localparam int DW  = 16;
  localparam int BW  = DW / 8;
  localparam int BL  = 8;
  localparam int CL0 = 2, RD0 = 0, CL1 = 3, RD1 = 1;
  localparam int NC  = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_start, rd_start;
  logic [DW-1:0] wr_data_in;
  logic [BW-1:0] wr_be;
  wire  [DW-1:0] dq0, dq1;
  logic [DW-1:0] dqv [2];
  logic [1:0]    mdl_oe;
  logic [DW-1:0] mdl_dat [2];
  logic [BW-1:0] dqm [2];
  logic [DW-1:0] rdo [2];
  logic [1:0]    req, vld, busy, done;

  assign dq0 = mdl_oe[0] ? mdl_dat[0] : 'z;
  assign dq1 = mdl_oe[1] ? mdl_dat[1] : 'z;
  assign dqv[0] = dq0;
  assign dqv[1] = dq1;

  always #5 clk = ~clk;

  sdram_dq_path #(.DQ_W(DW), .BURST_LEN(BL), .CAS_LAT(CL0), .RD_DLY(RD0), .CNT_W(9)) dut0 (
    .clk(clk), .rst_n(rst_n), .sdram_data(dq0), .sdram_dqm(dqm[0]), .wr_start(wr_start),
    .wr_data_in(wr_data_in),
`ifdef SDRAM_DQM_EN
    .wr_be(wr_be),
`endif
    .wr_data_req(req[0]), .rd_start(rd_start), .rd_data_out(rdo[0]),
    .rd_data_valid(vld[0]), .busy(busy[0]), .burst_done(done[0]));

  sdram_dq_path #(.DQ_W(DW), .BURST_LEN(BL), .CAS_LAT(CL1), .RD_DLY(RD1), .CNT_W(9)) dut1 (
    .clk(clk), .rst_n(rst_n), .sdram_data(dq1), .sdram_dqm(dqm[1]), .wr_start(wr_start),
    .wr_data_in(wr_data_in),
`ifdef SDRAM_DQM_EN
    .wr_be(wr_be),
`endif
    .wr_data_req(req[1]), .rd_start(rd_start), .rd_data_out(rdo[1]),
    .rd_data_valid(vld[1]), .busy(busy[1]), .burst_done(done[1]));

  // Expected per-cycle behaviour, cycle k = the interval after the k-th edge following the start.
  logic          e_busy [2][NC], e_req [2][NC], e_vld [2][NC], e_done [2][NC], e_mdl [2][NC];
  logic [DW-1:0] e_bus [2][NC], e_rdo [2][NC];
  logic [BW-1:0] e_dqm [2][NC];
  logic [DW-1:0] wq [BL], rq [BL], last_rd [2];
  logic [BW-1:0] beq [BL];
  int            n_chk = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int lat(input int d);
    return (d == 0) ? CL0 + RD0 : CL1 + RD1;
  endfunction

  task automatic plan(input bit is_wr);
    logic [DW-1:0] r;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < NC; k++) begin
        e_busy[d][k] = 1'b0; e_req[d][k] = 1'b0; e_vld[d][k] = 1'b0; e_done[d][k] = 1'b0;
        e_mdl[d][k]  = 1'b1; e_bus[d][k] = DW'($urandom); e_dqm[d][k] = '0;
      end
      if (is_wr) begin
        for (int k = 0; k <= BL + 1; k++) e_busy[d][k] = 1'b1;
        for (int k = 0; k < BL; k++) e_req[d][k] = 1'b1;
        for (int k = 1; k <= BL; k++) begin
          e_mdl[d][k] = 1'b0;
          e_bus[d][k] = wq[k-1];
`ifdef SDRAM_DQM_EN
          e_dqm[d][k] = ~beq[k-1];
`endif
        end
        e_done[d][BL+1] = 1'b1;
      end else begin
        for (int k = 0; k <= lat(d) + BL; k++) e_busy[d][k] = 1'b1;
        for (int j = 0; j < BL; j++) begin
          e_bus[d][lat(d)+j]   = rq[j];
          e_vld[d][lat(d)+j+1] = 1'b1;
        end
        e_done[d][lat(d)+BL] = 1'b1;
      end
      r = last_rd[d];
      for (int k = 0; k < NC; k++) begin
        if (e_vld[d][k]) r = e_bus[d][k-1];
        e_rdo[d][k] = r;
      end
    end
  endtask

  task automatic check_cycle(input int k);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d.c%0d busy", d, k), busy[d], e_busy[d][k]);
      check($sformatf("d%0d.c%0d wr_data_req", d, k), req[d], e_req[d][k]);
      check($sformatf("d%0d.c%0d rd_data_valid", d, k), vld[d], e_vld[d][k]);
      check($sformatf("d%0d.c%0d burst_done", d, k), done[d], e_done[d][k]);
      check($sformatf("d%0d.c%0d rd_data_out", d, k), rdo[d], e_rdo[d][k]);
      check($sformatf("d%0d.c%0d sdram_dqm", d, k), dqm[d], e_dqm[d][k]);
      check($sformatf("d%0d.c%0d dq", d, k), dqv[d], e_bus[d][k]);
    end
  endtask

  task automatic check_idle(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s d%0d busy", tag, d), busy[d], 0);
      check($sformatf("%s d%0d wr_data_req", tag, d), req[d], 0);
      check($sformatf("%s d%0d rd_data_valid", tag, d), vld[d], 0);
      check($sformatf("%s d%0d burst_done", tag, d), done[d], 0);
      check($sformatf("%s d%0d rd_data_out", tag, d), rdo[d], last_rd[d]);
      check($sformatf("%s d%0d sdram_dqm", tag, d), dqm[d], 0);
      check($sformatf("%s d%0d dq released", tag, d), dqv[d], mdl_dat[d]);
    end
  endtask

  task automatic feed(input int hp);
    if (hp < BL) begin
      wr_data_in = wq[hp];
      wr_be      = beq[hp];
    end else begin
      wr_data_in = DW'($urandom);
      wr_be      = BW'($urandom);
    end
  endtask

  // kind: 0 write, 1 read, 2 write+read same cycle, 3 rd_start mid-write,
  //       4 reset during word 4 of a write, 5 wr_start mid-read
  task automatic run_txn(input int kind);
    bit is_wr, stop, req_seen;
    int hp;
    is_wr    = (kind != 1 && kind != 5);
    plan(is_wr);
    hp       = is_wr ? 0 : BL;
    req_seen = 1'b0;
    stop     = 1'b0;
    @(posedge clk); #1;
    wr_start = is_wr;
    rd_start = (kind == 1 || kind == 2 || kind == 5);
    feed(hp);
    for (int k = 0; k < NC && !stop; k++) begin
      @(posedge clk); #1;
      if (req_seen && hp < BL) hp++;
      wr_start = (kind == 5 && k == 2);
      rd_start = (kind == 3 && k == 3);
      feed(hp);
      for (int d = 0; d < 2; d++) begin
        mdl_oe[d]  = e_mdl[d][k];
        mdl_dat[d] = e_bus[d][k];
      end
      @(negedge clk);
      req_seen = req[0];
      check_cycle(k);
      if (kind == 4 && k == 4) begin
        #1;
        rst_n      = 1'b0;
        mdl_oe     = '1;
        mdl_dat[0] = DW'($urandom);
        mdl_dat[1] = DW'($urandom);
        last_rd[0] = '0;
        last_rd[1] = '0;
        #1;
        check_idle("mid_burst_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        stop  = 1'b1;
      end
    end
    wr_start = 1'b0;
    rd_start = 1'b0;
    if (!stop) begin
      last_rd[0] = e_rdo[0][NC-1];
      last_rd[1] = e_rdo[1][NC-1];
    end
  endtask

  task automatic new_data();
    for (int i = 0; i < BL; i++) begin
      wq[i]  = DW'($urandom);
      rq[i]  = DW'($urandom);
      beq[i] = BW'($urandom);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    wr_start   = 1'b0;
    rd_start   = 1'b0;
    wr_data_in = '0;
    wr_be      = '1;
    mdl_oe     = '1;
    mdl_dat[0] = 16'h1234;
    mdl_dat[1] = 16'h4321;
    last_rd[0] = '0;
    last_rd[1] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("in_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_idle("after_reset");
    end

    for (int i = 0; i < BL; i++) begin
      wq[i]  = DW'(i + 1);
      rq[i]  = 16'hA000 + DW'(i);
      beq[i] = (i == 2) ? BW'(1) : {BW{1'b1}};
    end
    run_txn(0);
    run_txn(1);
    new_data(); run_txn(2);
    new_data(); run_txn(3);
    new_data(); run_txn(1);
    new_data(); run_txn(4);
    new_data(); run_txn(0);
    new_data(); run_txn(5);
    new_data(); run_txn(1);
    repeat (16) begin
      new_data();
      run_txn(int'($urandom_range(0, 5)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
